cnt_sched: RTL and testbench

CNT_SCHED -- requirements
Module: cnt_sched

---
 rtl/cnt_sched_pkg.sv | 14 +
 rtl/cnt_sched_arb.sv | 36 +++
 rtl/cnt_sched.sv | 109 ++++++++++
 tb/tb_cnt_sched.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/cnt_sched_pkg.sv
// Shared types and constants for the counter-datapath scheduler.
package cnt_sched_pkg;

  localparam int NUM_REQ   = 2;
  localparam int LEN_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    RUN   = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/cnt_sched_arb.sv
// Two-way arbiter producing a one-hot winner. CNT_SCHED_RR_EN selects round-robin
// (with its last-served pointer); otherwise requester 0 has fixed priority.
module cnt_sched_arb
  import cnt_sched_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               upd_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] win_o
);

`ifdef CNT_SCHED_RR_EN
  logic last_q;

  // On a tie the requester that was not served last wins.
  always_comb begin
    win_o = req_i;
    if (req_i == 2'b11) win_o = last_q ? 2'b01 : 2'b10;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni)    last_q <= 1'b1;
    else if (upd_i) last_q <= win_o[1];
  end
`else
  logic unused;
  assign unused = ^{clk_i, rst_ni, upd_i};

  always_comb begin
    win_o = req_i;
    if (req_i[0]) win_o = 2'b01;
  end
`endif

endmodule

// File: rtl/cnt_sched.sv
// Scheduler granting a shared counter datapath to one of two requesters for a
// programmable run length. Arbitration policy set by CNT_SCHED_RR_EN (see cnt_sched_arb).
module cnt_sched
  import cnt_sched_pkg::*;
#(
  parameter int LEN_W = LEN_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [LEN_W-1:0]   len0_i,
  input  logic [LEN_W-1:0]   len1_i,
  input  logic               abort_i,
  output logic               slt_o,
  output logic               en_o,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [NUM_REQ-1:0] done_o,
  output logic               busy_o
);

  state_e             state_q;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               slt_q, en_q, busy_q;
  logic [NUM_REQ-1:0] gnt_q, done_q;
  logic [NUM_REQ-1:0] win;
  logic               arb_upd;

  assign arb_upd = (state_q == IDLE) && (req_i != '0);
  assign cnt_d   = cnt_q - LEN_W'(1);

  cnt_sched_arb u_arb (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .upd_i  (arb_upd),
    .req_i  (req_i),
    .win_o  (win)
  );

  // Outputs are registered alongside the state so each reflects the state it is in.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      slt_q   <= 1'b0;
      en_q    <= 1'b0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      done_q <= '0;
      unique case (state_q)
        IDLE: begin
          if (req_i != '0) begin
            state_q <= GRANT;
            gnt_q   <= win;
            slt_q   <= win[1];
            busy_q  <= 1'b1;
            cnt_q   <= win[1] ? len1_i : len0_i;
          end
        end
        GRANT: begin
          if (abort_i) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else if (cnt_q == '0) begin
            state_q <= FIN;
            gnt_q   <= '0;
            done_q  <= gnt_q;
          end else begin
            state_q <= RUN;
            en_q    <= 1'b1;
          end
        end
        RUN: begin
          if (abort_i) begin
            state_q <= IDLE;
            en_q    <= 1'b0;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
          end else begin
            // Counter holds remaining En cycles including this one; stops at zero.
            cnt_q <= cnt_d;
            if (cnt_q == LEN_W'(1)) begin
              state_q <= FIN;
              en_q    <= 1'b0;
              gnt_q   <= '0;
              done_q  <= gnt_q;
            end
          end
        end
        FIN: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign slt_o  = slt_q;
  assign en_o   = en_q;
  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Bench for cnt_sched: transaction-level queue model checked every cycle, a vector
// table, hand sequences for tie/abort/reset, and a randomized phase.
module tb_cnt_sched;

  localparam int LW = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    req = 2'b00;
  logic [LW-1:0] len0 = '0, len1 = '0;
  logic          abort = 1'b0;
  logic          slt, en, busy;
  logic [1:0]    gnt, done;

  always #5 clk = ~clk;

  cnt_sched #(.LEN_W(LW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .len0_i(len0), .len1_i(len1),
    .abort_i(abort), .slt_o(slt), .en_o(en), .gnt_o(gnt), .done_o(done), .busy_o(busy)
  );

  int n_cmp = 0, n_err = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model: each grant expands to an output schedule
  typedef struct packed {
    logic       busy;
    logic [1:0] gnt;
    logic       slt;
    logic       en;
    logic [1:0] done;
  } out_t;

  out_t exp_o = '0;
  out_t sched[$];
  logic last_m = 1'b1;
  out_t dut_o;
  assign dut_o = {busy, gnt, slt, en, done};

  function automatic logic pick(input logic [1:0] r, input logic last);
`ifdef CNT_SCHED_RR_EN
    return (r == 2'b11) ? ~last : r[1];
`else
    return ~r[0];
`endif
  endfunction

  always @(posedge clk) begin
    logic w;
    logic [1:0] oh;
    int L;
    if (!rst_n) begin
      sched.delete();
      exp_o  = '0;
      last_m = 1'b1;
    end else if (exp_o.gnt != 2'b00 && abort) begin
      sched.delete();
      exp_o = '{busy: 1'b0, gnt: 2'b00, slt: exp_o.slt, en: 1'b0, done: 2'b00};
    end else if (sched.size() != 0) begin
      exp_o = sched.pop_front();
    end else if (req != 2'b00) begin
      w      = pick(req, last_m);
      last_m = w;
      oh     = w ? 2'b10 : 2'b01;
      L      = w ? int'(len1) : int'(len0);
      sched.push_back('{1'b1, oh, w, 1'b0, 2'b00});
      for (int i = 0; i < L; i++) sched.push_back('{1'b1, oh, w, 1'b1, 2'b00});
      sched.push_back('{1'b1, 2'b00, w, 1'b0, oh});
      sched.push_back('{1'b0, 2'b00, w, 1'b0, 2'b00});
      exp_o = sched.pop_front();
    end
  end

  always @(negedge clk) if (chk_on) chk("cycle_outputs", 32'(dut_o), 32'(exp_o));

  // ---------------- helpers
  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; req = 2'b00; abort = 1'b0;
    repeat (n) @(negedge clk);
    chk("reset_outputs", 32'(dut_o), 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic wait_busy(input logic want, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (busy === want) begin ok = 1'b1; break; end
    end
  endtask

  // Count En cycles and OR Done pulses until Busy drops (bounded).
  task automatic drain(output int en_n, output logic [1:0] dacc, output bit ok);
    en_n = 0; dacc = 2'b00; ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (en === 1'b1) en_n++;
      dacc |= done;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  typedef struct {
    logic [1:0]    req;
    logic [LW-1:0] l0, l1;
    logic [1:0]    gnt;
    int            en_n;
    logic [1:0]    done;
  } vec_t;

  vec_t tbl[7];

  initial begin
    bit ok;
    int en_n;
    logic [1:0] dacc;
    logic s;

    tbl[0] = '{2'b01, 8'd3,   8'd9, 2'b01, 3,   2'b01};
    tbl[1] = '{2'b10, 8'd9,   8'd0, 2'b10, 0,   2'b10};
    tbl[2] = '{2'b10, 8'd1,   8'd5, 2'b10, 5,   2'b10};
    tbl[3] = '{2'b01, 8'd0,   8'd4, 2'b01, 0,   2'b01};
    tbl[4] = '{2'b01, 8'd1,   8'd0, 2'b01, 1,   2'b01};
    tbl[5] = '{2'b10, 8'd0,   8'd1, 2'b10, 1,   2'b10};
    tbl[6] = '{2'b01, 8'hFF,  8'd2, 2'b01, 255, 2'b01};

    do_reset(2);
    chk_on = 1'b1;

    foreach (tbl[k]) begin
      req = tbl[k].req; len0 = tbl[k].l0; len1 = tbl[k].l1;
      wait_busy(1'b1, 5, ok);
      chk($sformatf("vec%0d_grant_seen", k), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_gnt", k), 32'(gnt), 32'(tbl[k].gnt));
      chk($sformatf("vec%0d_slt", k), 32'(slt), 32'(tbl[k].gnt[1]));
      req = 2'b00;
      drain(en_n, dacc, ok);
      chk($sformatf("vec%0d_finish", k), 32'(ok), 32'd1);
      chk($sformatf("vec%0d_en_cycles", k), 32'(en_n), 32'(tbl[k].en_n));
      chk($sformatf("vec%0d_done", k), 32'(dacc), 32'(tbl[k].done));
      @(negedge clk);
    end

    // Tie held: RR alternates 0,1,0; fixed priority keeps serving 0.
    do_reset(1);
    req = 2'b11; len0 = 8'd2; len1 = 8'd4;
    for (int k = 0; k < 3; k++) begin
      wait_busy(1'b1, 10, ok);
      chk($sformatf("tie%0d_grant_seen", k), 32'(ok), 32'd1);
      s = slt;
      drain(en_n, dacc, ok);
`ifdef CNT_SCHED_RR_EN
      chk($sformatf("tie%0d_slt", k), 32'(s), (k == 1) ? 32'd1 : 32'd0);
      chk($sformatf("tie%0d_en_cycles", k), 32'(en_n), (k == 1) ? 32'd4 : 32'd2);
`else
      chk($sformatf("tie%0d_slt", k), 32'(s), 32'd0);
      chk($sformatf("tie%0d_en_cycles", k), 32'(en_n), 32'd2);
`endif
    end
    req = 2'b00;
    wait_busy(1'b0, 20, ok);

    // Abort at 4th RUN cycle: straight to idle, Slt held, no Done afterwards.
    for (int v = 0; v < 2; v++) begin
      do_reset(1);
      req = 2'b10; len1 = 8'd10;
      wait_busy(1'b1, 5, ok);
      req = 2'b00;
      repeat (4) @(negedge clk);
      chk($sformatf("run4_en_%0d", v), 32'(en), 32'd1);
      if (v == 0) abort = 1'b1; else rst_n = 1'b0;
      @(negedge clk);
      abort = 1'b0; rst_n = 1'b1;
      chk($sformatf("kill_outputs_%0d", v), 32'(dut_o),
          (v == 0) ? 32'(out_t'{1'b0, 2'b00, 1'b1, 1'b0, 2'b00}) : 32'd0);
      dacc = 2'b00;
      repeat (12) begin @(negedge clk); dacc |= done; end
      chk($sformatf("kill_no_done_%0d", v), 32'(dacc), 32'd0);
    end

    // Abort in FIN/IDLE is ignored; randomized traffic against the model.
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      req   = 2'($urandom);
      len0  = LW'($urandom_range(0, 5));
      len1  = LW'($urandom_range(0, 5));
      abort = ($urandom_range(0, 15) == 0);
      rst_n = ($urandom_range(0, 99) != 0);
    end
    @(negedge clk);
    rst_n = 1'b1; abort = 1'b0; req = 2'b00;
    wait_busy(1'b0, 20, ok);
    chk("final_idle", 32'(ok), 32'd1);
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
